regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports CLK and RESET_N.
REQ-002 Ports SHALL be, clock and reset first:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- input_alu_req  in  1  ALU writeback request.
- input_alu_address  in  3  ALU destination register.
- input_alu_value  in  16  ALU result.
- output_alu_grant  out  1  ALU request accepted this cycle.
- input_mem_req  in  1  memory-load writeback request.
- input_mem_address  in  3  load destination register.
- input_mem_value  in  16  load data.
- output_mem_grant  out  1  memory request accepted this cycle.
- input_stall  in  1  freeze; no grants while high.
- output_reg_write  out  1  register-file write enable.
- output_reg_write_address  out  3  register-file write address.
- output_reg_write_value  out  16  register-file write data.
- output_pending_mask  out  8  one bit per register with a write accepted but not yet committed.
- output_write_count  out  16  committed-write counter.

Function
REQ-003 Requesters SHALL hold req, address and value stable until they see grant high at a rising edge.
- Grant is one cycle per accepted write.
- A requester MAY keep req high to present a new write on the next cycle.
REQ-004 Grants SHALL be combinational from current req, input_stall and the priority pointer.
- At most one grant per cycle.
- No grant while input_stall=1 or RESET_N=0.
REQ-005 A single active request SHALL be granted in the same cycle.
REQ-006 When both requests are active, the requester named by the priority pointer SHALL be granted.
- The pointer then moves to the other requester.
- With only one active request, the pointer SHALL also move to the non-granted requester.
REQ-007 The priority pointer SHALL reset to ALU.
REQ-008 Two-state FSM:
- IDLE -> WRITE on a grant.
- WRITE -> WRITE on a grant.
- WRITE -> IDLE when there is no grant.
- output_reg_write SHALL be 1 exactly in WRITE.
REQ-009 Address and value of the granted request SHALL be registered on the grant edge and driven on the output_reg_write_* ports.
- The commit therefore appears the cycle after the grant (latency 1).
- Sustained throughput SHALL be one write per cycle.
REQ-010 output_pending_mask:
- Bit for the granted address SHALL set on the grant edge and clear on the following edge when committed.
- A same-address re-grant in that cycle SHALL keep the bit set.
REQ-011 output_write_count SHALL increment by 1 per committed write and wrap from 16'hFFFF to 16'h0000.
REQ-012 Both requesters targeting the same register in one cycle SHALL be serialized in arbitration order.
- The later commit wins.
REQ-013 When input_stall rises while in WRITE, the in-flight commit SHALL still complete, then the FSM SHALL go to IDLE.

Reset
REQ-014 RESET_N low SHALL immediately force:
- FSM to IDLE.
- output_reg_write, both grants, output_pending_mask and output_write_count to 0.
- output_reg_write_address to 3'b000 and output_reg_write_value to 16'h0000.
- Priority pointer to ALU.
REQ-015 Reset asserted mid-operation SHALL discard any in-flight write; no commit SHALL occur.
REQ-016 The first grant SHALL be possible in the first cycle after RESET_N deasserts.

Configuration
REQ-017 Macro RF_ARB_R0_ZERO_EN SHALL control writes to register 0.
- Defined: writes to address 3'b000 SHALL still be granted and SHALL advance the pointer, but SHALL NOT assert output_reg_write, set pending bit 0, or increment the counter (R0 reads as zero).
- Undefined: register 0 SHALL be treated like all other registers.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Reset, then ALU req addr=1 value=16'h1234 -> grant that cycle; next cycle output_reg_write=1, addr=1, value=16'h1234, pending_mask=8'h02; following cycle mask=0, count=1.
- Both req every cycle (ALU addr=2 16'hAAAA, mem addr=3 16'hBBBB) for 4 cycles -> grants ALU, mem, ALU, mem; 4 back-to-back commits; count=4.
- Both req, same addr=5 (ALU 16'h1111, mem 16'h2222), pointer at ALU -> commit 16'h1111 then 16'h2222; mask bit5 high for 2 cycles.
- input_stall=1 with both req active for 3 cycles -> no grants, output_reg_write=0; release -> grant to pointer holder.
- RESET_N pulsed low on the grant cycle of a write to addr=4 -> no commit; all outputs 0; count=0.
- With RF_ARB_R0_ZERO_EN: ALU write addr=0 value=16'hFFFF -> granted; output_reg_write stays 0; count unchanged. Without the macro: committed; count=1.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Two-port register-file writeback arbiter: round-robin grant between ALU and memory,
// one registered commit per cycle. Optional macro RF_ARB_R0_ZERO_EN makes register 0 read-only-zero.
module regfile_write_arbiter (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        input_alu_req,
  input  logic [2:0]  input_alu_address,
  input  logic [15:0] input_alu_value,
  output logic        output_alu_grant,
  input  logic        input_mem_req,
  input  logic [2:0]  input_mem_address,
  input  logic [15:0] input_mem_value,
  output logic        output_mem_grant,
  input  logic        input_stall,
  output logic        output_reg_write,
  output logic [2:0]  output_reg_write_address,
  output logic [15:0] output_reg_write_value,
  output logic [7:0]  output_pending_mask,
  output logic [15:0] output_write_count
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  typedef enum logic {
    PTR_ALU = 1'b0,
    PTR_MEM = 1'b1
  } ptr_t;

  state_t      state_q, state_d;
  ptr_t        ptr_q;
  logic        grant_alu, grant_mem, any_grant, writable;
  logic [2:0]  sel_address;
  logic [15:0] sel_value;
  logic [2:0]  wr_address_q;
  logic [15:0] wr_value_q;
  logic [7:0]  pending_q, pending_d, set_bits, clear_bits;
  logic [15:0] count_q;

  // Grants are purely combinational so a lone request is accepted in the same cycle.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (RESET_N && !input_stall) begin
      if (input_alu_req && input_mem_req) begin
        if (ptr_q == PTR_ALU) grant_alu = 1'b1;
        else                  grant_mem = 1'b1;
      end else if (input_alu_req) begin
        grant_alu = 1'b1;
      end else if (input_mem_req) begin
        grant_mem = 1'b1;
      end
    end
  end

  assign any_grant   = grant_alu | grant_mem;
  assign sel_address = grant_mem ? input_mem_address : input_alu_address;
  assign sel_value   = grant_mem ? input_mem_value   : input_alu_value;

`ifdef RF_ARB_R0_ZERO_EN
  // A grant to R0 is accepted and advances the pointer but never becomes a commit.
  assign writable = any_grant && (sel_address != 3'd0);
`else
  assign writable = any_grant;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = writable ? ST_WRITE : ST_IDLE;
      ST_WRITE: state_d = writable ? ST_WRITE : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ptr_q <= PTR_ALU;
    end else if (any_grant) begin
      ptr_q <= grant_alu ? PTR_MEM : PTR_ALU;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_address_q <= 3'd0;
      wr_value_q   <= 16'h0000;
    end else if (writable) begin
      wr_address_q <= sel_address;
      wr_value_q   <= sel_value;
    end
  end

  // Clear the committing bit before setting the new one so a same-address re-grant stays set.
  always_comb begin
    set_bits   = 8'h00;
    clear_bits = 8'h00;
    if (writable)            set_bits   = 8'h01 << sel_address;
    if (state_q == ST_WRITE) clear_bits = 8'h01 << wr_address_q;
    pending_d = (pending_q & ~clear_bits) | set_bits;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) pending_q <= 8'h00;
    else          pending_q <= pending_d;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                 count_q <= 16'h0000;
    else if (state_q == ST_WRITE) count_q <= count_q + 16'd1;
  end

  assign output_alu_grant         = grant_alu;
  assign output_mem_grant         = grant_mem;
  assign output_reg_write         = (state_q == ST_WRITE);
  assign output_reg_write_address = wr_address_q;
  assign output_reg_write_value   = wr_value_q;
  assign output_pending_mask      = pending_q;
  assign output_write_count       = count_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: cycle-level transaction model plus literal spot checks.
`timescale 1ns/1ps
module tb_regfile_write_arbiter;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        alu_req = 1'b0, mem_req = 1'b0, stall = 1'b0;
  logic [2:0]  alu_addr = 3'd0, mem_addr = 3'd0;
  logic [15:0] alu_val = 16'h0, mem_val = 16'h0;
  logic        alu_grant, mem_grant, reg_write;
  logic [2:0]  reg_addr;
  logic [15:0] reg_val, write_count;
  logic [7:0]  pending_mask;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_write_arbiter dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .input_alu_req(alu_req), .input_alu_address(alu_addr), .input_alu_value(alu_val),
    .output_alu_grant(alu_grant),
    .input_mem_req(mem_req), .input_mem_address(mem_addr), .input_mem_value(mem_val),
    .output_mem_grant(mem_grant),
    .input_stall(stall),
    .output_reg_write(reg_write), .output_reg_write_address(reg_addr),
    .output_reg_write_value(reg_val), .output_pending_mask(pending_mask),
    .output_write_count(write_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: what the outputs must show during the current cycle.
  bit          m_prio_mem = 0;     // 1 = memory wins the next tie
  bit          m_write = 0;
  logic [2:0]  m_addr = 3'd0;
  logic [15:0] m_val = 16'h0;
  logic [15:0] m_count = 16'h0;

  always @(negedge CLK) begin
    bit e_alu, e_mem, drop;
    logic [2:0] a;
    logic [15:0] v;
    e_alu = 0; e_mem = 0;
    if (RESET_N && !stall) begin
      if (alu_req && mem_req) begin e_alu = !m_prio_mem; e_mem = m_prio_mem; end
      else begin e_alu = alu_req; e_mem = mem_req; end
    end
    if (!RESET_N) begin
      m_prio_mem = 0; m_write = 0; m_addr = 0; m_val = 0; m_count = 0;
    end
    chk("m_alu_grant", alu_grant, e_alu);
    chk("m_mem_grant", mem_grant, e_mem);
    chk("m_reg_write", reg_write, m_write);
    chk("m_addr", reg_addr, m_addr);
    chk("m_value", reg_val, m_val);
    chk("m_pending", pending_mask, m_write ? (8'h01 << m_addr) : 8'h00);
    chk("m_count", write_count, m_count);
    if (RESET_N) begin
      m_count = m_count + (m_write ? 16'd1 : 16'd0);
      m_write = 0;
      if (e_alu || e_mem) begin
        a = e_alu ? alu_addr : mem_addr;
        v = e_alu ? alu_val : mem_val;
        m_prio_mem = e_alu;
        drop = 0;
`ifdef RF_ARB_R0_ZERO_EN
        drop = (a == 3'd0);
`endif
        if (!drop) begin m_write = 1; m_addr = a; m_val = v; end
      end
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  initial begin
    logic [3:0] ga, gm;
    int wr;
    logic [15:0] cnt0;
    repeat (3) step();
    chk("reset_count", write_count, 16'h0);
    chk("reset_mask", pending_mask, 8'h00);
    chk("reset_write", reg_write, 1'b0);

    // Single ALU write
    RESET_N = 1; alu_req = 1; alu_addr = 3'd1; alu_val = 16'h1234;
    #1 chk("s1_grant", alu_grant, 1'b1);
    step(); alu_req = 0;
    #1 chk("s1_write", reg_write, 1'b1);
    chk("s1_addr", reg_addr, 3'd1);
    chk("s1_value", reg_val, 16'h1234);
    chk("s1_mask", pending_mask, 8'h02);
    step();
    chk("s1_mask_clr", pending_mask, 8'h00);
    chk("s1_count", write_count, 16'd1);

    // Alternating grants under contention, pointer reset to ALU
    RESET_N = 0; step(); RESET_N = 1;
    alu_req = 1; alu_addr = 3'd2; alu_val = 16'hAAAA;
    mem_req = 1; mem_addr = 3'd3; mem_val = 16'hBBBB;
    wr = 0;
    for (int i = 0; i < 4; i++) begin
      #1 ga[i] = alu_grant; gm[i] = mem_grant;
      step();
      wr += int'(reg_write);
    end
    alu_req = 0; mem_req = 0;
    chk("s2_alu_pattern", ga, 4'b0101);
    chk("s2_mem_pattern", gm, 4'b1010);
    chk("s2_b2b_writes", wr, 4);
    step();
    chk("s2_count", write_count, 16'd4);

    // Same address from both sides: ALU first, memory commit wins
    alu_req = 1; alu_addr = 3'd5; alu_val = 16'h1111;
    mem_req = 1; mem_addr = 3'd5; mem_val = 16'h2222;
    #1 chk("s3_alu_first", alu_grant, 1'b1);
    step(); alu_req = 0;
    #1 chk("s3_mem_second", mem_grant, 1'b1);
    chk("s3_val1", reg_val, 16'h1111);
    chk("s3_mask1", pending_mask, 8'h20);
    step(); mem_req = 0;
    chk("s3_val2", reg_val, 16'h2222);
    chk("s3_mask2", pending_mask, 8'h20);
    step();
    chk("s3_mask_clr", pending_mask, 8'h00);
    chk("s3_count", write_count, 16'd6);

    // Stall freezes arbitration
    stall = 1;
    alu_req = 1; alu_addr = 3'd6; alu_val = 16'h0606;
    mem_req = 1; mem_addr = 3'd7; mem_val = 16'h0707;
    for (int i = 0; i < 3; i++) begin
      #1 chk("s4_no_grant", {alu_grant, mem_grant}, 2'b00);
      step();
      chk("s4_no_write", reg_write, 1'b0);
    end
    stall = 0;
    #1 chk("s4_release_alu", alu_grant, 1'b1);
    step(); alu_req = 0;
    #1 chk("s4_then_mem", mem_grant, 1'b1);
    step(); mem_req = 0;
    step();
    chk("s4_count", write_count, 16'd8);

    // Reset on the grant cycle discards the write
    alu_req = 1; alu_addr = 3'd4; alu_val = 16'h4444; RESET_N = 0;
    #1 chk("s5_no_grant", alu_grant, 1'b0);
    step(); RESET_N = 1; alu_req = 0;
    #1 chk("s5_write", reg_write, 1'b0);
    chk("s5_mask", pending_mask, 8'h00);
    chk("s5_count", write_count, 16'd0);
    chk("s5_addr", reg_addr, 3'd0);
    chk("s5_value", reg_val, 16'h0);

    // Register 0 write
    cnt0 = write_count;
    alu_req = 1; alu_addr = 3'd0; alu_val = 16'hFFFF;
    #1 chk("s6_grant", alu_grant, 1'b1);
    step(); alu_req = 0;
`ifdef RF_ARB_R0_ZERO_EN
    chk("s6_write", reg_write, 1'b0);
    step();
    chk("s6_count", write_count, cnt0);
`else
    chk("s6_write", reg_write, 1'b1);
    step();
    chk("s6_count", write_count, cnt0 + 16'd1);
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
